// File: rtl/game_pkg.sv
// Shared game definitions: state codes seen by the visuals, plus the strike-count width helper
// used by the controller and bomb logic.
package game_pkg;

  localparam int GAME_STATE_W = 3;

  typedef enum logic [GAME_STATE_W-1:0] {
    WAITING      = 3'b000,
    START_GAME   = 3'b001,
    PLAYING_GAME = 3'b010,
    GAME_WON     = 3'b011,
    GAME_LOST    = 3'b100
  } game_state_t;

  function automatic int sw_width(input int max_strikes);
    return $clog2(max_strikes + 1);
  endfunction

endpackage

// File: rtl/strike_counter.sv
// Next strike count: adds strikes from still-unsolved modules to the running count,
// saturating at MAX_STRIKES.
module strike_counter
  import game_pkg::*;
#(
  parameter int NUM_MODULES = 5,
  parameter int MAX_STRIKES = 3,
  localparam int SW = sw_width(MAX_STRIKES)
) (
  input  logic [NUM_MODULES-1:0] i_strike,
  input  logic [NUM_MODULES-1:0] i_solved_mask,
  input  logic [SW-1:0]          i_count,
  output logic [SW-1:0]          o_count
);

  // 5 bits hold up to 16 simultaneous hits; 6 bits hold count (<=15) + hits
  logic [4:0] w_hits;
  logic [5:0] w_sum;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < NUM_MODULES; i++)
      w_hits = w_hits + 5'(i_strike[i] & ~i_solved_mask[i]);
    w_sum   = 6'(i_count) + 6'(w_hits);
    o_count = (w_sum >= 6'(MAX_STRIKES)) ? SW'(MAX_STRIKES) : w_sum[SW-1:0];
  end

endmodule

// File: rtl/game_controller.sv
// Bomb game controller: sequences setup, play and end-of-game states, tracks solved modules
// and strikes, and drives the timer/setup handshake pulses.
module game_controller
  import game_pkg::*;
#(
  parameter int NUM_MODULES   = 5,
  parameter int MAX_STRIKES   = 3,
  parameter int SETUP_TIMEOUT = 1024,
  localparam int SW = sw_width(MAX_STRIKES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   setup_complete,
  input  logic [NUM_MODULES-1:0] module_solved,
  input  logic [NUM_MODULES-1:0] strike,
  input  logic                   timer_expired,
  output logic                   begin_setup,
  output logic                   begin_timer,
  output logic                   stop_timer,
  output logic [2:0]             game_state,
  output logic [NUM_MODULES-1:0] solved_mask,
  output logic [SW-1:0]          strike_count,
  output logic                   setup_error
);

  localparam int CW = $clog2(SETUP_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETUP_TIMEOUT - 1);

  game_state_t            r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_begin_setup;
  logic                   r_begin_timer;
  logic                   r_stop_timer;
  logic [NUM_MODULES-1:0] r_solved;
  logic [SW-1:0]          r_strikes;
  logic                   r_setup_error;

  logic [NUM_MODULES-1:0] w_solved_next;
  logic [SW-1:0]          w_strikes_next;

  assign w_solved_next = r_solved | module_solved;

  // Strikes are masked by the solved set from before this cycle, so a module that
  // strikes in the same cycle it is solved still counts.
  strike_counter #(
    .NUM_MODULES (NUM_MODULES),
    .MAX_STRIKES (MAX_STRIKES)
  ) u_strike_counter (
    .i_strike      (strike),
    .i_solved_mask (r_solved),
    .i_count       (r_strikes),
    .o_count       (w_strikes_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= WAITING;
      r_cnt         <= '0;
      r_begin_setup <= 1'b0;
      r_begin_timer <= 1'b0;
      r_stop_timer  <= 1'b0;
      r_solved      <= '0;
      r_strikes     <= '0;
      r_setup_error <= 1'b0;
    end else begin
      r_begin_setup <= 1'b0;
      r_begin_timer <= 1'b0;
      case (r_state)
        WAITING: begin
          if (start) begin
            r_state       <= START_GAME;
            r_cnt         <= '0;
            r_solved      <= '0;
            r_strikes     <= '0;
            r_setup_error <= 1'b0;
            r_begin_setup <= 1'b1;
          end
        end
        START_GAME: begin
          if (setup_complete) begin
            r_state       <= PLAYING_GAME;
            r_begin_timer <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= WAITING;
            r_setup_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PLAYING_GAME: begin
          r_solved  <= w_solved_next;
          r_strikes <= w_strikes_next;
          // loss is checked first so it wins over a simultaneous final solve
          if (timer_expired || (w_strikes_next >= SW'(MAX_STRIKES))) begin
            r_state      <= GAME_LOST;
            r_stop_timer <= 1'b1;
          end else if (&w_solved_next) begin
            r_state      <= GAME_WON;
            r_stop_timer <= 1'b1;
          end
        end
        GAME_WON, GAME_LOST: begin
          if (start) begin
            r_state      <= WAITING;
            r_stop_timer <= 1'b0;
          end
        end
        default: r_state <= WAITING;
      endcase
    end
  end

  assign game_state   = r_state;
  assign begin_setup  = r_begin_setup;
  assign begin_timer  = r_begin_timer;
  assign stop_timer   = r_stop_timer;
  assign solved_mask  = r_solved;
  assign strike_count = r_strikes;
  assign setup_error  = r_setup_error;

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter NUM_MODULES, default 5, meaning the number of puzzle modules on the bomb (legal range 1..16).
REQ-002 The block SHALL have parameter MAX_STRIKES, default 3, meaning the strike count that loses the game (legal range 1..15).
REQ-003 The block SHALL have parameter SETUP_TIMEOUT, default 1024, meaning clock cycles allowed for setup_complete after begin_setup (legal ≥ 2).
REQ-004 The block SHALL have port clock, input, 1 bit: the single 27 MHz game clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: synchronous single-cycle start/acknowledge pulse.
REQ-007 The block SHALL have port setup_complete, input, 1 bit: pulse from bomb logic indicating setup is done.
REQ-008 The block SHALL have port module_solved, input, NUM_MODULES bits: per-module solve pulse.
REQ-009 The block SHALL have port strike, input, NUM_MODULES bits: per-module strike pulse.
REQ-010 The block SHALL have port timer_expired, input, 1 bit: countdown timer reached zero.
REQ-011 The block SHALL have port begin_setup, output, 1 bit: one-cycle pulse to bomb logic.
REQ-012 The block SHALL have port begin_timer, output, 1 bit: one-cycle pulse to countdown timer.
REQ-013 The block SHALL have port stop_timer, output, 1 bit: level, freezes the timer.
REQ-014 The block SHALL have port game_state, output, 3 bits: current state code, driven to visuals.
REQ-015 The block SHALL have port solved_mask, output, NUM_MODULES bits: sticky per-module solved flags.
REQ-016 The block SHALL have port strike_count, output, SW = $clog2(MAX_STRIKES+1) bits: strikes accrued.
REQ-017 The block SHALL have port setup_error, output, 1 bit: sticky flag, last setup timed out.

Function
REQ-018 The state machine SHALL use states WAITING=000, START_GAME=001, PLAYING_GAME=010, GAME_WON=011, GAME_LOST=100, with game_state equal to the registered state code.
REQ-019 In WAITING, start=1 SHALL move the FSM to START_GAME next cycle, clear solved_mask, strike_count, and setup_error, and assert begin_setup for exactly that first START_GAME cycle.
REQ-020 In START_GAME, a cycle counter SHALL start at 0 on entry; setup_complete=1 SHALL move the FSM to PLAYING_GAME, with begin_timer high for exactly the first PLAYING_GAME cycle.
REQ-021 If setup_complete has not been seen when the counter reaches SETUP_TIMEOUT-1, the FSM SHALL return to WAITING and set setup_error; setup_complete in that same cycle wins, giving PLAYING_GAME with no error.
REQ-022 In PLAYING_GAME, solved_mask SHALL be updated as solved_mask | module_solved each cycle.
REQ-023 In PLAYING_GAME, strike_count SHALL add popcount(strike & ~solved_mask) each cycle, saturating at MAX_STRIKES; strikes from already-solved modules SHALL be ignored.
REQ-024 Loss SHALL occur when timer_expired=1 or the updated strike_count ≥ MAX_STRIKES, taking the FSM to GAME_LOST next cycle.
REQ-025 Win SHALL occur when the updated solved_mask is all ones and no loss condition is present, taking the FSM to GAME_WON next cycle.
REQ-026 When win and loss are simultaneous, loss SHALL take priority.
REQ-027 stop_timer SHALL be 1 in GAME_WON and GAME_LOST and 0 otherwise.
REQ-028 In GAME_WON and GAME_LOST, all inputs except start SHALL be ignored, and start=1 SHALL return the FSM to WAITING while holding solved_mask and strike_count for display.
REQ-029 Inputs outside their active state (e.g. setup_complete in WAITING) SHALL have no effect.
REQ-030 begin_setup and begin_timer SHALL be registered outputs, never high simultaneously or for more than one cycle.

Reset
REQ-031 reset=0 SHALL immediately, asynchronously force state WAITING, with all outputs and the setup counter at 0, from any state including mid-game.
REQ-032 Release of reset SHALL take effect on the first rising clock edge with reset=1, and no pulse output SHALL fire on release.

Structure
REQ-033 State codes and the SW width function SHALL reside in shared package game_pkg, for reuse by the visuals and bomb-logic blocks.
REQ-034 Strike accumulation (masked popcount plus saturating add) SHALL be a sub-module strike_counter, parameterised by NUM_MODULES and MAX_STRIKES.

Verification
REQ-035 Bench: reset, start, setup_complete 10 cycles later -> begin_setup pulse in cycle 1, begin_timer pulse once, game_state=010.
REQ-036 Bench: start with no setup_complete, SETUP_TIMEOUT=16 -> return to WAITING after 16 cycles in START_GAME, setup_error=1; next start clears setup_error.
REQ-037 Bench: NUM_MODULES=5, solve bits 0-3, then strike[4] and strike[0] in the same cycle -> strike_count+1 only.
REQ-038 Bench: two strikes, then third-strike pulse in the same cycle as final module_solved -> GAME_LOST, stop_timer=1.
REQ-039 Bench: timer_expired in PLAYING_GAME -> GAME_LOST; start -> WAITING, solved_mask held.
REQ-040 Bench: reset asserted mid-PLAYING_GAME between clock edges -> outputs 0 and game_state=000 without waiting for a clock edge.
